// File: rtl/universal_register_if.sv
// Bus bundle for universal_register: control/data in, register state out.
interface universal_register_if #(
   parameter int unsigned WIDTH = 8
);
   logic             preset;
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             wrap;
   logic             zero;

   // Driver side: issues operations, observes register state
   modport master (
      output preset, en, mode, d, sin,
      input  q, sout, wrap, zero
   );

   // Register side: consumes operations, presents state
   modport slave (
      input  preset, en, mode, d, sin,
      output q, sout, wrap, zero
   );
endinterface

// File: rtl/universal_register.sv
// WIDTH-bit universal register: sync clear/preset, load, shift, rotate, up/down count.
module universal_register #(
   parameter int unsigned     WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
   input logic                 clk,
   input logic                 reset,
   universal_register_if.slave bus
);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_LOAD  = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_SHR   = 3'b011;
   localparam logic [2:0] MODE_ROL   = 3'b100;
   localparam logic [2:0] MODE_ROR   = 3'b101;
   localparam logic [2:0] MODE_CUP   = 3'b110;
   localparam logic [2:0] MODE_CDN   = 3'b111;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ALL_ZERO = '0;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   // Shifting needs at least two bits to have a distinct msb and lsb
   if (WIDTH < 2) begin : g_width_check
      $error("universal_register: WIDTH must be >= 2");
   end

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             sout_r;
   logic             sout_nxt;
   logic             wrap_r;
   logic             wrap_nxt;

   // Next-state for the enabled operation; d/sin only read by modes that use them
   always_comb begin
      q_nxt    = q_r;
      sout_nxt = sout_r;
      wrap_nxt = 1'b0;
      if (bus.en) begin
         case (bus.mode)
            MODE_HOLD: begin
               q_nxt = q_r;
            end
            MODE_LOAD: begin
               q_nxt = bus.d;
            end
            MODE_SHL: begin
               q_nxt    = {q_r[WIDTH-2:0], bus.sin};
               sout_nxt = q_r[WIDTH-1];
            end
            MODE_SHR: begin
               q_nxt    = {bus.sin, q_r[WIDTH-1:1]};
               sout_nxt = q_r[0];
            end
            MODE_ROL: begin
               q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
               sout_nxt = q_r[WIDTH-1];
            end
            MODE_ROR: begin
               q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
               sout_nxt = q_r[0];
            end
            MODE_CUP: begin
               q_nxt    = q_r + ONE;
               wrap_nxt = (q_r == ALL_ONES);
            end
            MODE_CDN: begin
               q_nxt    = q_r - ONE;
               wrap_nxt = (q_r == ALL_ZERO);
            end
            default: begin
               q_nxt = q_r;
            end
         endcase
      end
   end

   // State register: reset beats preset beats the enabled operation
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r    <= RESET_VALUE;
         sout_r <= 1'b0;
         wrap_r <= 1'b0;
      end else if (bus.preset) begin
         q_r    <= PRESET_VALUE;
         sout_r <= 1'b0;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         sout_r <= sout_nxt;
         wrap_r <= wrap_nxt;
      end
   end

   assign bus.q    = q_r;
   assign bus.sout = sout_r;
   assign bus.wrap = wrap_r;
   assign bus.zero = (q_r == ALL_ZERO);

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register (WIDTH=8, default reset/preset values).
module tb_universal_register;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   universal_register_if #(.WIDTH(8)) bus ();

   universal_register #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                          input logic ew, input logic ez);
      chk({tag, ".q"},    bus.q,            eq);
      chk({tag, ".sout"}, {7'd0, bus.sout}, {7'd0, es});
      chk({tag, ".wrap"}, {7'd0, bus.wrap}, {7'd0, ew});
      chk({tag, ".zero"}, {7'd0, bus.zero}, {7'd0, ez});
   endtask

   task automatic drive(input logic p, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic s);
      bus.preset = p;
      bus.en     = e;
      bus.mode   = m;
      bus.d      = dd;
      bus.sin    = s;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      // Reset wins over preset and a pending load
      reset = 1'b1;
      drive(1'b1, 1'b1, 3'b001, 8'h5A, 1'b0);
      step();
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b1);

      // Preset
      reset = 1'b0;
      drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0);
      step();
      chk_all("preset", 8'hFF, 1'b0, 1'b0, 1'b0);

      // Load A5
      drive(1'b0, 1'b1, 3'b001, 8'hA5, 1'b0);
      step();
      chk_all("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);

      // Disabled for three cycles with garbage on d/mode
      drive(1'b0, 1'b0, 3'b110, 8'hxx, 1'bx);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("en0_hold.q", bus.q, 8'hA5);
      end

      // Preset beats an enabled load
      drive(1'b1, 1'b1, 3'b001, 8'h12, 1'b0);
      step();
      chk("preset_vs_load.q", bus.q, 8'hFF);

      // Hold mode with X on d and sin
      drive(1'b0, 1'b1, 3'b000, 8'hxx, 1'bx);
      step();
      chk_all("hold_mode", 8'hFF, 1'b0, 1'b0, 1'b0);

      // Shift left then right
      drive(1'b0, 1'b1, 3'b001, 8'h81, 1'b0);
      step();
      chk("load_81.q", bus.q, 8'h81);
      drive(1'b0, 1'b1, 3'b010, 8'hxx, 1'b0);
      step();
      chk_all("shl", 8'h02, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 3'b011, 8'hxx, 1'b1);
      step();
      chk_all("shr", 8'h81, 1'b0, 1'b0, 1'b0);

      // Rotate left, then eight rotate rights return to start
      drive(1'b0, 1'b1, 3'b001, 8'h81, 1'b0);
      step();
      drive(1'b0, 1'b1, 3'b100, 8'hxx, 1'bx);
      step();
      chk_all("rol", 8'h03, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 3'b101, 8'hxx, 1'bx);
      step();
      chk_all("ror1", 8'h81, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step();
      chk_all("ror8", 8'h03, 1'b0, 1'b0, 1'b0);

      // Count up across the wrap
      drive(1'b0, 1'b1, 3'b001, 8'hFE, 1'b1);
      step();
      chk("load_fe.q", bus.q, 8'hFE);
      drive(1'b0, 1'b1, 3'b110, 8'hxx, 1'bx);
      step();
      chk_all("cup_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("cup_00", 8'h00, 1'b0, 1'b1, 1'b1);
      step();
      chk_all("cup_01", 8'h01, 1'b0, 1'b0, 1'b0);

      // Count down across the wrap
      drive(1'b0, 1'b1, 3'b111, 8'hxx, 1'bx);
      step();
      chk_all("cdn_00", 8'h00, 1'b0, 1'b0, 1'b1);
      step();
      chk_all("cdn_ff", 8'hFF, 1'b0, 1'b1, 1'b0);

      // Disable clears the wrap pulse
      drive(1'b0, 1'b0, 3'b111, 8'hxx, 1'bx);
      step();
      chk_all("en0_after_wrap", 8'hFF, 1'b0, 1'b0, 1'b0);

      // Reset on the wrapping edge leaves no wrap pulse
      drive(1'b0, 1'b1, 3'b110, 8'hxx, 1'bx);
      reset = 1'b1;
      step();
      chk_all("reset_on_wrap", 8'h00, 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      step();
      chk_all("resume_01", 8'h01, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("resume_02", 8'h02, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
